// File: rtl/vga_stream_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : vga_stream_monitor
// Description : Checks a VGA pixel stream's counts and timing strobes, tracks
//               lock, line length and frame count, and samples one pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_stream_monitor #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 628,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int HS_START    = 840,
    parameter int HS_END      = 968,
    parameter int VS_START    = 601,
    parameter int VS_END      = 605,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    input  logic        clr_err,
    output logic        locked,
    output logic [3:0]  err_flags,
    output logic [7:0]  err_count,
    output logic [15:0] frame_count,
    output logic [10:0] h_total_meas,
    output logic [11:0] probe_rgb,
    output logic        probe_valid
);

    localparam logic [10:0] c_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_H_ACTIVE = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACTIVE = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(HS_START);
    localparam logic [10:0] c_HS_END   = 11'(HS_END);
    localparam logic [10:0] c_VS_START = 11'(VS_START);
    localparam logic [10:0] c_VS_END   = 11'(VS_END);
    localparam logic [15:0] c_LOCK_FRAMES = 16'(LOCK_FRAMES);

    localparam logic [1:0] c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0] c_ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED   = 2'd2;

    // Sample S (registered inputs) and previous sample P
    logic        r_s_valid;
    logic [10:0] r_s_hc;
    logic [10:0] r_s_vc;
    logic        r_s_hs;
    logic        r_s_hb;
    logic        r_s_vs;
    logic        r_s_vb;
    logic [11:0] r_s_rgb;
    logic [10:0] r_s_px;
    logic [10:0] r_s_py;
    logic        r_s_clr;
    logic        r_p_valid;
    logic [10:0] r_p_hc;
    logic [10:0] r_p_vc;

    logic [1:0]  r_state;
    logic [15:0] r_good;
    logic [10:0] r_hcyc;
    logic        r_hrun;

    logic        w_hwrap;
    logic [10:0] w_exp_hc;
    logic [10:0] w_exp_vc;
    logic        w_seq_mm;
    logic        w_hs_mm;
    logic        w_blk_mm;
    logic        w_vs_mm;
    logic [3:0]  w_flags;
    logic        w_err;
    logic        w_sof;
    logic        w_line_start;
    logic        w_probe;
    logic [15:0] w_good_next;

    assign w_hwrap  = (r_p_hc == c_H_LAST);
    assign w_exp_hc = w_hwrap ? 11'd0 : r_p_hc + 11'd1;
    assign w_exp_vc = !w_hwrap ? r_p_vc :
                      ((r_p_vc == c_V_LAST) ? 11'd0 : r_p_vc + 11'd1);

    assign w_seq_mm = r_p_valid && ((r_s_hc != w_exp_hc) || (r_s_vc != w_exp_vc));
    assign w_hs_mm  = r_s_hs != ((r_s_hc >= c_HS_START) && (r_s_hc < c_HS_END));
    assign w_blk_mm = (r_s_hb != (r_s_hc >= c_H_ACTIVE)) ||
                      (r_s_vb != (r_s_vc >= c_V_ACTIVE));
    assign w_vs_mm  = r_s_vs != ((r_s_vc >= c_VS_START) && (r_s_vc < c_VS_END));

    assign w_flags      = r_s_valid ? {w_vs_mm, w_blk_mm, w_hs_mm, w_seq_mm} : 4'b0000;
    assign w_err        = |w_flags;
    assign w_sof        = r_s_valid && (r_s_hc == 11'd0) && (r_s_vc == 11'd0);
    assign w_line_start = r_s_valid && (r_s_hc == 11'd0);
    assign w_probe      = r_s_valid && (r_s_hc == r_s_px) && (r_s_vc == r_s_py) &&
                          !r_s_hb && !r_s_vb;
    assign w_good_next  = r_good + 16'd1;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_hc    <= 11'd0;
            r_s_vc    <= 11'd0;
            r_s_hs    <= 1'b0;
            r_s_hb    <= 1'b0;
            r_s_vs    <= 1'b0;
            r_s_vb    <= 1'b0;
            r_s_rgb   <= 12'd0;
            r_s_px    <= 11'd0;
            r_s_py    <= 11'd0;
            r_s_clr   <= 1'b0;
            r_p_valid <= 1'b0;
            r_p_hc    <= 11'd0;
            r_p_vc    <= 11'd0;
        end else begin
            r_s_valid <= 1'b1;
            r_s_hc    <= hcount_in;
            r_s_vc    <= vcount_in;
            r_s_hs    <= hsync_in;
            r_s_hb    <= hblnk_in;
            r_s_vs    <= vsync_in;
            r_s_vb    <= vblnk_in;
            r_s_rgb   <= rgb_in;
            r_s_px    <= probe_x;
            r_s_py    <= probe_y;
            r_s_clr   <= clr_err;
            if (r_s_valid) begin
                r_p_valid <= 1'b1;
                r_p_hc    <= r_s_hc;
                r_p_vc    <= r_s_vc;
            end
        end
    end

    // A clear coinciding with an error leaves exactly that error recorded
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            err_flags <= 4'd0;
            err_count <= 8'd0;
        end else if (r_s_clr) begin
            err_flags <= w_flags;
            err_count <= {7'd0, w_err};
        end else begin
            err_flags <= err_flags | w_flags;
            if (w_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_count  <= 16'd0;
            h_total_meas <= 11'd0;
            r_hcyc       <= 11'd0;
            r_hrun       <= 1'b0;
            probe_rgb    <= 12'd0;
            probe_valid  <= 1'b0;
        end else begin
            if (w_sof) begin
                frame_count <= frame_count + 16'd1;
            end
            if (w_line_start) begin
                if (r_hrun) begin
                    h_total_meas <= r_hcyc;
                end
                r_hcyc <= 11'd1;
                r_hrun <= 1'b1;
            end else if (r_hrun && (r_hcyc != 11'h7FF)) begin
                r_hcyc <= r_hcyc + 11'd1;
            end
            probe_valid <= w_probe;
            if (w_probe) begin
                probe_rgb <= r_s_rgb;
            end
        end
    end

    // Error beats SOF; an error-free SOF is the only way forward
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_UNLOCKED;
            r_good  <= 16'd0;
            locked  <= 1'b0;
        end else if (w_err) begin
            r_state <= c_ST_UNLOCKED;
            locked  <= 1'b0;
        end else if (w_sof) begin
            case (r_state)
                c_ST_UNLOCKED: begin
                    r_state <= c_ST_ACQUIRE;
                    r_good  <= 16'd0;
                end
                c_ST_ACQUIRE: begin
                    r_good <= w_good_next;
                    if (w_good_next >= c_LOCK_FRAMES) begin
                        r_state <= c_ST_LOCKED;
                        locked  <= 1'b1;
                    end
                end
                c_ST_LOCKED: begin
                    r_state <= c_ST_LOCKED;
                end
                default: begin
                    r_state <= c_ST_UNLOCKED;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_monitor.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_stream_monitor
// Description : Directed scoreboard bench for vga_stream_monitor on a reduced
//               40x12 raster (30x9 visible).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_stream_monitor;

    localparam int HT = 40;
    localparam int VT = 12;
    localparam int HA = 30;
    localparam int VA = 9;
    localparam int HSS = 32;
    localparam int HSE = 36;
    localparam int VSS = 10;
    localparam int VSE = 11;
    localparam int LF = 2;
    localparam int PIX_X = 29;
    localparam int PIX_Y = 8;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] probe_x = 11'(PIX_X);
    logic [10:0] probe_y = 11'(PIX_Y);
    logic        clr_err = 1'b0;
    logic        locked;
    logic [3:0]  err_flags;
    logic [7:0]  err_count;
    logic [15:0] frame_count;
    logic [10:0] h_total_meas;
    logic [11:0] probe_rgb;
    logic        probe_valid;

    vga_stream_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE),
        .LOCK_FRAMES(LF)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y),
        .clr_err(clr_err), .locked(locked), .err_flags(err_flags),
        .err_count(err_count), .frame_count(frame_count),
        .h_total_meas(h_total_meas), .probe_rgb(probe_rgb),
        .probe_valid(probe_valid)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct { int cyc; int sel; logic [15:0] exp; } chk_t;
    typedef struct { int cyc; logic [11:0] rgb; } prb_t;
    chk_t chk_q[$];
    prb_t prb_q[$];
    int nvec = 0;
    int nfail = 0;

    int cur_h = 0;
    int cur_v = 0;
    int last_h = 0;
    int last_v = 0;
    bit f_hs_low = 1'b0;
    bit f_bad_vb = 1'b0;
    bit f_clr = 1'b0;

    function automatic logic [15:0] get_out(int sel);
        case (sel)
            0: return {15'd0, locked};
            1: return {12'd0, err_flags};
            2: return {8'd0, err_count};
            3: return frame_count;
            4: return {5'd0, h_total_meas};
            5: return {4'd0, probe_rgb};
            default: return {15'd0, probe_valid};
        endcase
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            0: return "locked";
            1: return "err_flags";
            2: return "err_count";
            3: return "frame_count";
            4: return "h_total_meas";
            5: return "probe_rgb";
            default: return "probe_valid";
        endcase
    endfunction

    task automatic expect_at(int dly, int sel, logic [15:0] v);
        chk_t c;
        c.cyc = cyc + dly;
        c.sel = sel;
        c.exp = v;
        chk_q.push_back(c);
    endtask

    // Drive n consecutive pixels of an ideal raster, with optional corruption
    task automatic step(int n);
        prb_t p;
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            hcount_in = 11'(cur_h);
            vcount_in = 11'(cur_v);
            hblnk_in  = (cur_h >= HA);
            hsync_in  = (cur_h >= HSS) && (cur_h < HSE) && !f_hs_low;
            vblnk_in  = (cur_v >= VA) ^ f_bad_vb;
            vsync_in  = (cur_v >= VSS) && (cur_v < VSE);
            clr_err   = f_clr;
            rgb_in    = (cur_h == PIX_X && cur_v == PIX_Y) ? 12'hF00 :
                        12'((cur_h * 7 + cur_v * 13) & 255);
            if (cur_h == int'(probe_x) && cur_v == int'(probe_y) && !hblnk_in && !vblnk_in) begin
                p.cyc = cyc + 2;
                p.rgb = rgb_in;
                prb_q.push_back(p);
            end
            last_h = cur_h;
            last_v = cur_v;
            cur_h++;
            if (cur_h == HT) begin
                cur_h = 0;
                cur_v = (cur_v == VT - 1) ? 0 : cur_v + 1;
            end
        end
    endtask

    task automatic sofs(int k);
        int n = 0;
        while (n < k) begin
            step(1);
            if (last_h == 0 && last_v == 0) n++;
        end
    endtask

    always @(negedge pclk) begin : monitor
        int i;
        logic [15:0] got;
        prb_t p;
        i = 0;
        while (i < chk_q.size()) begin
            if (chk_q[i].cyc <= cyc) begin
                got = get_out(chk_q[i].sel);
                nvec++;
                if (got !== chk_q[i].exp) begin
                    nfail++;
                    $display("FAIL %s cycle %0d: got %0h, expected %0h",
                             sel_name(chk_q[i].sel), cyc, got, chk_q[i].exp);
                end
                chk_q.delete(i);
            end else begin
                i++;
            end
        end
        if (prb_q.size() > 0 && prb_q[0].cyc < cyc) begin
            p = prb_q.pop_front();
            nvec++;
            nfail++;
            $display("FAIL probe_missing cycle %0d: got no probe_valid, expected rgb %0h", p.cyc, p.rgb);
        end
        if (probe_valid === 1'b1) begin
            nvec++;
            if (prb_q.size() == 0) begin
                nfail++;
                $display("FAIL probe_unexpected cycle %0d: got probe_valid rgb %0h, expected none", cyc, probe_rgb);
            end else begin
                p = prb_q.pop_front();
                if (p.cyc != cyc || probe_rgb !== p.rgb) begin
                    nfail++;
                    $display("FAIL probe cycle %0d: got rgb %0h, expected rgb %0h at cycle %0d",
                             cyc, probe_rgb, p.rgb, p.cyc);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge pclk);
        for (int s = 0; s < 7; s++) expect_at(1, s, 16'd0);
        repeat (2) @(negedge pclk);

        // Ideal stream: lock on the third SOF
        step(1);
        rst = 1'b0;
        sofs(2);
        expect_at(1, 0, 16'd0);
        expect_at(2, 0, 16'd1);
        expect_at(2, 1, 16'd0);
        expect_at(2, 2, 16'd0);
        expect_at(2, 3, 16'd3);
        expect_at(2, 4, 16'(HT));

        // hsync held low through one line's pulse
        step(HT - 1 - last_h);
        f_hs_low = 1'b1;
        step(HT);
        f_hs_low = 1'b0;
        expect_at(2, 1, 16'b0010);
        expect_at(2, 2, 16'(HSE - HSS));
        expect_at(2, 0, 16'd0);
        sofs(3);
        expect_at(1, 0, 16'd0);
        expect_at(2, 0, 16'd1);
        expect_at(2, 3, 16'd6);
        expect_at(2, 1, 16'b0010);

        // Clear on a clean cycle
        f_clr = 1'b1;
        step(1);
        f_clr = 1'b0;
        expect_at(2, 1, 16'd0);
        expect_at(2, 2, 16'd0);
        expect_at(2, 0, 16'd1);

        // hcount skips 20 -> 22
        step(20 - last_h);
        cur_h = 22;
        step(1);
        expect_at(2, 1, 16'b0001);
        expect_at(2, 2, 16'd1);
        expect_at(2, 0, 16'd0);

        // Clear coinciding with a vblnk mismatch
        f_clr = 1'b1;
        f_bad_vb = 1'b1;
        step(1);
        f_clr = 1'b0;
        f_bad_vb = 1'b0;
        expect_at(2, 1, 16'b0100);
        expect_at(2, 2, 16'd1);
        f_clr = 1'b1;
        step(1);
        f_clr = 1'b0;
        expect_at(2, 1, 16'd0);
        expect_at(2, 2, 16'd0);

        // The shortened line measures one cycle less
        step(HT - 1 - last_h);
        step(1);
        expect_at(2, 4, 16'(HT - 1));

        // err_count saturates
        f_bad_vb = 1'b1;
        step(260);
        f_bad_vb = 1'b0;
        expect_at(2, 2, 16'd255);
        expect_at(2, 1, 16'b0100);
        f_clr = 1'b1;
        step(1);
        f_clr = 1'b0;
        expect_at(2, 2, 16'd0);

        // Relock, probe captured; then a probe inside blanking for a frame
        sofs(3);
        expect_at(2, 0, 16'd1);
        expect_at(2, 5, 16'hF00);
        probe_x = 11'd35;
        sofs(1);
        probe_x = 11'(PIX_X);

        // Asynchronous reset mid-frame while locked
        while (!(last_h == 20 && last_v == 6)) step(1);
        @(posedge pclk);
        #1;
        rst = 1'b1;
        for (int s = 0; s < 7; s++) expect_at(0, s, 16'd0);
        step(3);
        rst = 1'b0;
        expect_at(2, 1, 16'd0);
        expect_at(2, 2, 16'd0);
        expect_at(2, 3, 16'd0);
        step(1);
        expect_at(2, 1, 16'd0);
        expect_at(2, 2, 16'd0);
        sofs(3);
        expect_at(1, 0, 16'd0);
        expect_at(2, 0, 16'd1);
        expect_at(2, 3, 16'd3);
        expect_at(2, 1, 16'd0);
        expect_at(2, 4, 16'(HT));

        repeat (4) @(negedge pclk);
        #1;
        if (chk_q.size() != 0 || prb_q.size() != 0) begin
            nvec++;
            nfail++;
            $display("FAIL leftover: got %0d pending checks and %0d pending probes, expected 0",
                     chk_q.size(), prb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
